// File: rtl/freelist_pkg.sv
// Free-list shared types: controller state, default tag and pointer widths.
// Imported by freelist_ctrl and freelist_tag_array.
package freelist_pkg;

    localparam int TAG_W = 8;
    localparam int PTR_W = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/freelist_tag_array.sv
// Free-tag storage: RPORT async read ports, WPORT sync free-write ports
// plus one sync init-write port. Contents are not reset.
// Ports: clk, rd_addr/rd_data (read), init_en/init_addr/init_data,
//        wr_en/wr_addr/wr_data (free writes).
module freelist_tag_array
    import freelist_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int INDEX = PTR_W,
    parameter int WIDTH = TAG_W,
    parameter int RPORT = 2,
    parameter int WPORT = 2
) (
    input  logic                        clk,
    input  logic [RPORT-1:0][INDEX-1:0] rd_addr,
    output logic [RPORT-1:0][WIDTH-1:0] rd_data,
    input  logic                        init_en,
    input  logic [INDEX-1:0]            init_addr,
    input  logic [WIDTH-1:0]            init_data,
    input  logic [WPORT-1:0]            wr_en,
    input  logic [WPORT-1:0][INDEX-1:0] wr_addr,
    input  logic [WPORT-1:0][WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Init and free writes never overlap: frees are gated off in INIT.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end
        for (int j = 0; j < WPORT; j++) begin
            if (wr_en[j]) begin
                mem[wr_addr[j]] <= wr_data[j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < RPORT; k++) begin
            rd_data[k] = mem[rd_addr[k]];
        end
    end

endmodule

// File: rtl/freelist_ctrl.sv
// Physical-tag free list: INIT loads BASE..BASE+DEPTH-1, RUN allocates
// all-or-nothing from head, frees compact at tail, flush rewinds head to
// the committed pointer. Optional checker: define FREELIST_CHECK_EN.
// Ports: clk, reset_n (async, active-low); alloc_req_i/alloc_tag_o/
//        alloc_ok_o; free_valid_i/free_tag_i; commit_cnt_i; flush_i;
//        ready_o (init done); count_o (free entries); err_o (sticky).
module freelist_ctrl
    import freelist_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int INDEX = PTR_W,
    parameter int WIDTH = TAG_W,
    parameter int BASE  = 32,
    parameter int RPORT = 2,
    parameter int WPORT = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [RPORT-1:0]            alloc_req_i,
    output logic [RPORT-1:0][WIDTH-1:0] alloc_tag_o,
    output logic                        alloc_ok_o,
    input  logic [WPORT-1:0]            free_valid_i,
    input  logic [WPORT-1:0][WIDTH-1:0] free_tag_i,
    input  logic [$clog2(RPORT):0]      commit_cnt_i,
    input  logic                        flush_i,
    output logic                        ready_o,
    output logic [INDEX:0]              count_o,
    output logic                        err_o
);

    typedef logic [INDEX-1:0] idx_t;
    typedef logic [INDEX:0]   cnt_t;
    typedef logic [WIDTH-1:0] wtag_t;

    state_t state;
    idx_t   init_cnt;
    idx_t   head;
    idx_t   tail;
    idx_t   commit_head;
    cnt_t   count;
    cnt_t   outstanding;
    logic   ready_q;

    logic                        run;
    logic [WPORT-1:0]            fv;
    cnt_t                        n_req;
    cnt_t                        m_free;
    cnt_t                        granted;
    cnt_t                        commit_ext;
    idx_t                        commit_head_next;
    logic [RPORT-1:0][INDEX-1:0] rd_addr;
    logic [WPORT-1:0][INDEX-1:0] free_addr;
    wtag_t                       init_data;

    assign run = (state == RUN);

    // Frees are ignored outside RUN.
    assign fv = run ? free_valid_i : '0;

    always_comb begin
        n_req = '0;
        for (int k = 0; k < RPORT; k++) begin
            n_req = n_req + cnt_t'(alloc_req_i[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < RPORT; k++) begin
            rd_addr[k] = head + idx_t'(k);
        end
    end

    // Valid frees pack into consecutive slots from tail in port order.
    always_comb begin
        m_free = '0;
        for (int j = 0; j < WPORT; j++) begin
            free_addr[j] = tail + m_free[INDEX-1:0];
            m_free       = m_free + cnt_t'(fv[j]);
        end
    end

    // Grant is judged against the registered count, so same-cycle
    // frees cannot be handed out until the next cycle.
    assign alloc_ok_o = run && !flush_i && (count >= n_req);
    assign granted    = alloc_ok_o ? n_req : '0;
    assign commit_ext = run ? cnt_t'(commit_cnt_i) : '0;

    assign commit_head_next = commit_head + commit_ext[INDEX-1:0];

    assign init_data = wtag_t'(BASE) + wtag_t'(init_cnt);

    freelist_tag_array #(
        .DEPTH (DEPTH),
        .INDEX (INDEX),
        .WIDTH (WIDTH),
        .RPORT (RPORT),
        .WPORT (WPORT)
    ) u_tags (
        .clk       (clk),
        .rd_addr   (rd_addr),
        .rd_data   (alloc_tag_o),
        .init_en   (!run),
        .init_addr (init_cnt),
        .init_data (init_data),
        .wr_en     (fv),
        .wr_addr   (free_addr),
        .wr_data   (free_tag_i)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            init_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            count       <= '0;
            outstanding <= '0;
            ready_q     <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    init_cnt <= init_cnt + idx_t'(1);
                    if (init_cnt == idx_t'(DEPTH - 1)) begin
                        state       <= RUN;
                        ready_q     <= 1'b1;
                        head        <= '0;
                        tail        <= '0;
                        commit_head <= '0;
                        count       <= cnt_t'(DEPTH);
                        outstanding <= '0;
                    end
                end
                RUN: begin
                    tail        <= tail + m_free[INDEX-1:0];
                    commit_head <= commit_head_next;
                    if (flush_i) begin
                        // Uncommitted allocations return to the pool
                        // by rewinding head to the committed point.
                        head        <= commit_head_next;
                        count       <= count + m_free
                                     + (outstanding - commit_ext);
                        outstanding <= '0;
                    end else begin
                        head        <= head + granted[INDEX-1:0];
                        count       <= count - granted + m_free;
                        outstanding <= outstanding + granted - commit_ext;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign count_o = count;

`ifdef FREELIST_CHECK_EN
    typedef logic [INDEX+1:0] wide_t;

    logic  err_q;
    logic  err_set;
    logic  noncontig;
    wide_t fill;

    always_comb begin
        noncontig = 1'b0;
        for (int k = 1; k < RPORT; k++) begin
            if (alloc_req_i[k] && !alloc_req_i[k-1]) begin
                noncontig = 1'b1;
            end
        end
        fill    = wide_t'(count) + wide_t'(m_free);
        err_set = 1'b0;
        if (run) begin
            err_set = (fill > wide_t'(DEPTH))
                   || (commit_ext > outstanding)
                   || noncontig;
        end else begin
            err_set = |free_valid_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl (DEPTH=16, BASE=32): init, alloc,
// free, commit, flush and sticky error, with an expected-tag queue.
module tb_freelist_ctrl;
    import freelist_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      alloc_req_i;
    logic [1:0][7:0] alloc_tag_o;
    logic            alloc_ok_o;
    logic [1:0]      free_valid_i;
    logic [1:0][7:0] free_tag_i;
    logic [1:0]      commit_cnt_i;
    logic            flush_i;
    logic            ready_o;
    logic [4:0]      count_o;
    logic            err_o;

    int   n_chk  = 0;
    int   n_fail = 0;
    tag_t exp_q[$];
    logic exp_err;

    always #5 clk = ~clk;

    freelist_ctrl #(
        .DEPTH (16),
        .INDEX (4),
        .WIDTH (8),
        .BASE  (32),
        .RPORT (2),
        .WPORT (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alloc_req_i  (alloc_req_i),
        .alloc_tag_o  (alloc_tag_o),
        .alloc_ok_o   (alloc_ok_o),
        .free_valid_i (free_valid_i),
        .free_tag_i   (free_tag_i),
        .commit_cnt_i (commit_cnt_i),
        .flush_i      (flush_i),
        .ready_o      (ready_o),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_req_i  = '0;
        free_valid_i = '0;
        free_tag_i   = '0;
        commit_cnt_i = '0;
        flush_i      = 1'b0;
    endtask

    // Async reset, then 16 INIT cycles; ready rises after the 16th edge.
    task automatic do_init(input string tag);
        #3 reset_n = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, 32'(ready_o), 0);
        chk({tag, "_rst_count"}, 32'(count_o), 0);
        chk({tag, "_rst_err"}, 32'(err_o), 0);
        @(negedge clk);
        idle();
        alloc_req_i = 2'b11;
        chk({tag, "_init_ok"}, 32'(alloc_ok_o), 0);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk({tag, "_ready_early"}, 32'(ready_o), 0);
        chk({tag, "_init_ok2"}, 32'(alloc_ok_o), 0);
        @(negedge clk);
        idle();
        #1;
        chk({tag, "_ready"}, 32'(ready_o), 1);
        chk({tag, "_count16"}, 32'(count_o), 16);
    endtask

    task automatic alloc(input logic [1:0] req, input tag_t t0,
                         input tag_t t1, input string tag);
        @(negedge clk);
        idle();
        alloc_req_i = req;
        if (req[0]) exp_q.push_back(t0);
        if (req[1]) exp_q.push_back(t1);
        #1;
        chk({tag, "_ok"}, 32'(alloc_ok_o), 1);
        if (req[0]) chk({tag, "_tag0"}, 32'(alloc_tag_o[0]),
                        32'(exp_q.pop_front()));
        if (req[1]) chk({tag, "_tag1"}, 32'(alloc_tag_o[1]),
                        32'(exp_q.pop_front()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        idle();

        // Reset release and init load.
        do_init("init");
        chk("init_tag0", 32'(alloc_tag_o[0]), 32);
        chk("init_tag1", 32'(alloc_tag_o[1]), 33);

        // Drain all 16 tags in order, wrapping head.
        for (int i = 0; i < 8; i++) begin
            alloc(2'b11, tag_t'(32 + 2 * i), tag_t'(33 + 2 * i), "drain");
        end
        @(negedge clk);
        idle();
        chk("drain_count0", 32'(count_o), 0);
        alloc_req_i = 2'b01;
        #1;
        chk("empty_ok", 32'(alloc_ok_o), 0);

        // Frees when empty are not allocatable in the same cycle.
        @(negedge clk);
        idle();
        alloc_req_i   = 2'b11;
        free_valid_i  = 2'b11;
        free_tag_i[0] = 8'd40;
        free_tag_i[1] = 8'd41;
        #1;
        chk("free_same_ok", 32'(alloc_ok_o), 0);
        @(negedge clk);
        idle();
        chk("free_count2", 32'(count_o), 2);
        alloc(2'b11, 8'd40, 8'd41, "refree");
        @(negedge clk);
        idle();
        chk("refree_count0", 32'(count_o), 0);

        // Mid-run reset, then alloc 6, commit 2, flush.
        do_init("reinit");
        alloc(2'b11, 8'd32, 8'd33, "a6a");
        alloc(2'b11, 8'd34, 8'd35, "a6b");
        alloc(2'b11, 8'd36, 8'd37, "a6c");
        @(negedge clk);
        idle();
        chk("a6_count10", 32'(count_o), 10);
        commit_cnt_i = 2'd2;
        @(negedge clk);
        idle();
        flush_i     = 1'b1;
        alloc_req_i = 2'b11;
        #1;
        chk("flush_blocks_ok", 32'(alloc_ok_o), 0);
        @(negedge clk);
        idle();
        chk("flush_count14", 32'(count_o), 14);
        alloc(2'b01, 8'd34, 8'd0, "post_flush");
        @(negedge clk);
        idle();
        chk("pf_count13", 32'(count_o), 13);

        // Flush with one free and one commit, three outstanding.
        alloc(2'b11, 8'd35, 8'd36, "out3");
        @(negedge clk);
        idle();
        chk("out3_count11", 32'(count_o), 11);
        flush_i       = 1'b1;
        commit_cnt_i  = 2'd1;
        free_valid_i  = 2'b01;
        free_tag_i[0] = 8'd50;
        @(negedge clk);
        idle();
        chk("flush2_count14", 32'(count_o), 14);
        alloc(2'b11, 8'd35, 8'd36, "post_flush2");
        @(negedge clk);
        idle();
        chk("pf2_count12", 32'(count_o), 12);

        // Overfill: sticky error only with the checker built in.
        do_init("ovf");
`ifdef FREELIST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        idle();
        free_valid_i  = 2'b01;
        free_tag_i[0] = 8'd60;
        @(negedge clk);
        idle();
        chk("ovf_err", 32'(err_o), 32'(exp_err));
        repeat (3) @(negedge clk);
        chk("ovf_err_sticky", 32'(err_o), 32'(exp_err));
        #2 reset_n = 1'b0;
        #1;
        chk("ovf_err_clr", 32'(err_o), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/freelist_ctrl.md
FREELIST_CTRL -- requirements
Module: freelist_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of free-tag entries, a power of two.
REQ-002 SHALL have parameter INDEX, default 4: log2(DEPTH).
REQ-003 SHALL have parameter WIDTH, default 8: physical tag width.
REQ-004 SHALL have parameter BASE, default 32: first tag loaded at init (SIZE_RMT).
REQ-005 SHALL have parameter RPORT, default 2: allocate ports.
REQ-006 SHALL have parameter WPORT, default 2: free ports.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port alloc_req_i, input, RPORT bits: per-port allocate request, lowest-contiguous.
REQ-010 SHALL have port alloc_tag_o, output, RPORT x WIDTH bits: tag for each port.
REQ-011 SHALL have port alloc_ok_o, output, 1 bit: all requested ports granted this cycle.
REQ-012 SHALL have port free_valid_i, input, WPORT bits: per-port free strobe.
REQ-013 SHALL have port free_tag_i, input, WPORT x WIDTH bits: tags returned at commit.
REQ-014 SHALL have port commit_cnt_i, input, log2(RPORT)+1 bits: allocations retired this cycle.
REQ-015 SHALL have port flush_i, input, 1 bit: squash all uncommitted allocations.
REQ-016 SHALL have port ready_o, output, 1 bit: init complete.
REQ-017 SHALL have port count_o, output, INDEX+1 bits: free entries.
REQ-018 SHALL have port err_o, output, 1 bit: sticky protocol error.

Function
REQ-019 SHALL use states INIT and RUN; INIT writes entry i = BASE+i, one per cycle, i = 0..DEPTH-1, then goes to RUN after DEPTH cycles.
REQ-020 SHALL hold ready_o=0 and alloc_ok_o=0 in INIT and ignore all inputs there.
REQ-021 SHALL enter RUN with head=0, tail=0, commit_head=0, count=DEPTH, outstanding=0.
REQ-022 SHALL drive alloc_tag_o[k] combinationally from entry (head+k) mod DEPTH, with zero latency.
REQ-023 SHALL grant all-or-nothing: alloc_ok_o=1 iff RUN and !flush_i and registered count >= popcount(alloc_req_i).
REQ-024 SHALL, when granted, advance head by the number of requests (n) and outstanding by n.
REQ-025 SHALL compact valid free ports in port order into entries tail, tail+1, ...; tail advances by the freed count m.
REQ-026 SHALL not make tags freed this cycle allocatable before the next cycle; count_next = count - granted + m.
REQ-027 SHALL advance commit_head by commit_cnt_i and set outstanding -= commit_cnt_i each cycle.
REQ-028 SHALL on flush_i apply frees and commit first, then set head <= commit_head_next, count <= count + m + (outstanding - commit_cnt_i), outstanding <= 0.
REQ-029 SHALL wrap all pointers modulo DEPTH; full/empty is distinguished by count only.
REQ-030 SHALL drive count_o from the registered count.

Reset
REQ-031 SHALL on reset_n=0, asynchronously, go to INIT with init counter=0, head=tail=commit_head=0, count=0, outstanding=0, err_o=0, ready_o=0, alloc_ok_o=0.
REQ-032 SHALL restart INIT from entry 0 when reset is asserted mid-INIT or mid-RUN.
REQ-033 SHALL not reset tag storage; INIT loads it.

Configuration
REQ-034 SHALL with FREELIST_CHECK_EN defined set err_o sticky on: count + m > DEPTH, commit_cnt_i > outstanding, non-contiguous alloc_req_i, or a free during INIT.
REQ-035 SHALL without FREELIST_CHECK_EN tie err_o to 0 and include no check logic.

Structure
REQ-036 SHALL place in package freelist_pkg: the state enum (INIT, RUN), the tag typedef and the pointer typedef.
REQ-037 SHALL keep storage in sub-module freelist_tag_array: RPORT async read ports, WPORT+1 sync write ports (one for init).

Verification (DEPTH=16, BASE=32)
REQ-038 SHALL check: reset release, then 16 cycles -> ready_o=1 on cycle 17, count_o=16, alloc_tag_o={33,32}.
REQ-039 SHALL check: 8 cycles of alloc_req=2'b11 -> tags 32..47 in order, count_o=0, then alloc_ok_o=0 with req=2'b01.
REQ-040 SHALL check: count=0, free tags 40 and 41 the same cycle, req=2'b11 -> alloc_ok_o=0 that cycle, =1 next with tags {41,40}.
REQ-041 SHALL check: alloc 6, commit 2, flush -> head=2, count_o=14, next alloc returns tag 34.
REQ-042 SHALL check: flush together with free of 1 tag and commit_cnt=1, outstanding=3 -> count_o = old + 1 + 2.
REQ-043 SHALL check, with FREELIST_CHECK_EN: free when count=16 -> err_o=1 and it stays 1 until reset_n=0.
